// File: rtl/rbm_dma_pkg.sv
// Shared types and defaults for the RBM accelerator DMA engines.
//   dma_state_t : transfer sequencing states (IDLE, REQ, STREAM, FIN)
//   DEF_*       : default widths for address, memory data, bus and length
//   beat_count  : number of bus beats needed to move a given element count
package rbm_dma_pkg;

    localparam int DEF_ADDR_W = 9;
    localparam int DEF_MEM_W  = 8;
    localparam int DEF_BUS_W  = 32;
    localparam int DEF_LEN_W  = 16;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        STREAM,
        FIN
    } dma_state_t;

    // Beats for len elements: one per element, or four elements per beat when packing.
    function automatic logic [31:0] beat_count(input logic [31:0] len, input logic pack);
        return pack ? ((len >> 2) + {31'd0, (len[1:0] != 2'd0)}) : len;
    endfunction

endpackage

// File: rtl/dma_store_fifo.sv
// Two-entry FIFO holding outgoing DMA write beats.
//   clk, rst   : clock, asynchronous active-high reset
//   step       : global advance enable; nothing changes while low
//   push/push_data : write one entry (caller guarantees space)
//   pop        : remove the head entry (ignored when empty)
//   head/valid : current head entry and non-empty flag
//   count      : number of stored entries (0..2)
module dma_store_fifo #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         step,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         valid,
    output logic [1:0]   count
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   cnt_q;
    logic         do_pop;

    assign do_pop = pop && (cnt_q != 2'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < 2; k++) begin
                mem_q[k] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= '0;
        end else if (step) begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, do_pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign valid = (cnt_q != 2'd0);
    assign count = cnt_q;

endmodule

// File: rtl/dma_store.sv
// Write-direction DMA engine: streams the byte-wide predict-result memory to
// the host over the DMA write channel (request/grant, valid/ready beats,
// completion pulse).
//   clk, rst, step         : clock, async active-high reset, global advance enable
//   start, cfg_wr_index, cfg_wr_length : transfer launch and configuration
//   wr_request, wr_index, wr_length, wr_grant : DMA write request handshake
//   data_out, data_out_valid, data_out_ready  : write beat stream
//   wr_complete, done, busy, i                : status
//   mem_addr, mem_ren, mem_rdata              : result memory read port (1-cycle latency)
// Build option: DMA_STORE_PACK_EN packs four consecutive bytes per beat
// (little-endian, zero-padded final beat); otherwise one byte per beat.
module dma_store
    import rbm_dma_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int MEM_W  = DEF_MEM_W,
    parameter int BUS_W  = DEF_BUS_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step,
    input  logic              start,
    input  logic [31:0]       cfg_wr_index,
    input  logic [LEN_W-1:0]  cfg_wr_length,
    output logic              wr_request,
    output logic [31:0]       wr_index,
    output logic [31:0]       wr_length,
    input  logic              wr_grant,
    output logic [BUS_W-1:0]  data_out,
    output logic              data_out_valid,
    input  logic              data_out_ready,
    output logic              wr_complete,
    output logic              done,
    output logic              busy,
    output logic [LEN_W-1:0]  i,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_ren,
    input  logic [MEM_W-1:0]  mem_rdata
);

    dma_state_t       state_q, state_d;
    logic [31:0]      idx_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] i_q;
    logic             done_q;
    logic             inflight_q;
    logic [1:0]       fifo_count;
    logic             fifo_valid;
    logic [BUS_W-1:0] fifo_head;
    logic             fifo_push;
    logic             fifo_pop;
    logic [BUS_W-1:0] push_data;
    logic [2:0]       occ;
    logic             issue;
    logic             last_beat;

    assign fifo_pop = step && fifo_valid && data_out_ready;

    // A beat popped this cycle frees its slot in time for a new read, which is
    // what keeps one element per cycle flowing with ready held high.
`ifdef DMA_STORE_PACK_EN
    logic [BUS_W-1:0] pk_data_q;
    logic [1:0]       pk_cnt_q;
    logic [2:0]       lanes;

    // A word under assembly owns a FIFO slot from its first read onward, so
    // only the first byte of each word needs the slot check.
    assign lanes     = {1'b0, pk_cnt_q} + {2'b0, inflight_q};
    assign occ       = {1'b0, fifo_count} + {2'b0, (lanes != 3'd0)};
    assign fifo_push = step && inflight_q && ((pk_cnt_q == 2'd3) || (i_q == len_q));
    assign issue     = step && (state_q == STREAM) && (i_q < len_q) &&
                       (((lanes != 3'd0) && (lanes < 3'd4)) || (occ < 3'd2) || fifo_pop);
    assign last_beat = fifo_pop && (fifo_count == 2'd1) && !inflight_q &&
                       (i_q == len_q) && (pk_cnt_q == 2'd0);

    always_comb begin
        push_data = pk_data_q;
        for (int unsigned k = 0; k < 4; k++) begin
            if (pk_cnt_q == k[1:0]) begin
                push_data[k*MEM_W +: MEM_W] = mem_rdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pk_data_q <= '0;
            pk_cnt_q  <= '0;
        end else if (step) begin
            if ((state_q == IDLE) && start) begin
                pk_data_q <= '0;
                pk_cnt_q  <= '0;
            end else if (inflight_q) begin
                if (fifo_push) begin
                    pk_data_q <= '0;
                    pk_cnt_q  <= '0;
                end else begin
                    pk_data_q <= push_data;
                    pk_cnt_q  <= pk_cnt_q + 2'd1;
                end
            end
        end
    end
`else
    assign occ       = {1'b0, fifo_count} + {2'b0, inflight_q};
    assign fifo_push = step && inflight_q;
    assign push_data = BUS_W'(mem_rdata);
    assign issue     = step && (state_q == STREAM) && (i_q < len_q) &&
                       ((occ < 3'd2) || fifo_pop);
    assign last_beat = fifo_pop && (fifo_count == 2'd1) && !inflight_q && (i_q == len_q);
`endif

    dma_store_fifo #(.W(BUS_W)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .step      (step),
        .push      (fifo_push),
        .push_data (push_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .valid     (fifo_valid),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            len_q      <= '0;
            i_q        <= '0;
            done_q     <= 1'b0;
            inflight_q <= 1'b0;
        end else if (step) begin
            state_q    <= state_d;
            inflight_q <= issue;
            if ((state_q == IDLE) && start) begin
                idx_q  <= cfg_wr_index;
                len_q  <= cfg_wr_length;
                i_q    <= '0;
                done_q <= 1'b0;
            end
            if (issue) begin
                i_q <= i_q + LEN_W'(1);
            end
            if (state_q == FIN) begin
                done_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_request  = 1'b0;
        wr_complete = 1'b0;
        busy        = 1'b1;
        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = (cfg_wr_length == '0) ? FIN : REQ;
                end
            end
            REQ: begin
                wr_request = 1'b1;
                if (wr_grant) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (last_beat) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                wr_complete = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign wr_index       = idx_q;
    assign wr_length      = 32'(len_q);
    assign data_out       = fifo_head;
    assign data_out_valid = fifo_valid;
    assign done           = done_q;
    assign i              = i_q;
    assign mem_addr       = i_q[ADDR_W-1:0];
    assign mem_ren        = issue;

endmodule

// File: tb/tb_dma_store.sv
module tb_dma_store;

    logic        clk = 1'b0;
    logic        rst;
    logic        step;
    logic        start;
    logic [31:0] cfg_wr_index;
    logic [15:0] cfg_wr_length;
    logic        wr_request;
    logic [31:0] wr_index;
    logic [31:0] wr_length;
    logic        wr_grant;
    logic [31:0] data_out;
    logic        data_out_valid;
    logic        data_out_ready;
    logic        wr_complete;
    logic        done;
    logic        busy;
    logic [15:0] i;
    logic [8:0]  mem_addr;
    logic        mem_ren;
    logic [7:0]  mem_rdata = '0;

    int checks = 0;
    int failures = 0;

    logic [7:0]  mem [512];
    logic [31:0] exp_q[$];
    logic [31:0] obs_beats[$];
    int          obs_beat_cyc[$];
    int obs_req, obs_first_req, obs_reads, obs_complete, obs_fin_cyc;
    int obs_max_out, obs_ren_nostep, obs_timeout;

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_ren) mem_rdata <= mem[mem_addr];

    dma_store dut (
        .clk(clk), .rst(rst), .step(step), .start(start),
        .cfg_wr_index(cfg_wr_index), .cfg_wr_length(cfg_wr_length),
        .wr_request(wr_request), .wr_index(wr_index), .wr_length(wr_length),
        .wr_grant(wr_grant), .data_out(data_out), .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready), .wr_complete(wr_complete), .done(done),
        .busy(busy), .i(i), .mem_addr(mem_addr), .mem_ren(mem_ren), .mem_rdata(mem_rdata)
    );

    // Reference: the ordered list of beats the host must receive for len elements.
    function automatic void build_expected(input int len);
        exp_q.delete();
`ifdef DMA_STORE_PACK_EN
        for (int w = 0; w < (len + 3) / 4; w++) begin
            logic [31:0] word;
            word = '0;
            for (int b = 0; b < 4; b++)
                if (4 * w + b < len) word[8*b +: 8] = mem[(4 * w + b) % 512];
            exp_q.push_back(word);
        end
`else
        for (int k = 0; k < len; k++) exp_q.push_back({24'h0, mem[k % 512]});
`endif
    endfunction

    function automatic void fill_mem_random();
        for (int k = 0; k < 512; k++) mem[k] = 8'($urandom);
    endfunction

    // Runs one transfer from IDLE, recording what the host side observes.
    // rmode: 0 ready=1, 1 ready pattern 1,0,0,..., 2 random ready
    // smode: 0 step=1, 1 random step, 2 step low for 3 cycles after 2 beats
    task automatic drive_xfer(input int len, input logic [31:0] idx, input int gdelay,
                              input int rmode, input int smode, input bit stray);
        int cyc, hold;
        bit fin, held;
        obs_beats.delete(); obs_beat_cyc.delete();
        obs_req = 0; obs_first_req = -1; obs_reads = 0; obs_complete = 0; obs_fin_cyc = -1;
        obs_max_out = 0; obs_ren_nostep = 0; obs_timeout = 0;
        step = 1'b1; start = 1'b1; cfg_wr_index = idx; cfg_wr_length = len[15:0];
        wr_grant = 1'b0; data_out_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; cfg_wr_index = $urandom; cfg_wr_length = 16'($urandom);
        cyc = 0; hold = 0; fin = 0; held = 0;
        while (!fin && cyc < 8 * len + 200) begin
            case (smode)
                1: step = ($urandom_range(0, 3) != 0);
                2: begin
                    if (!held && obs_beats.size() == 2) begin hold = 3; held = 1; end
                    step = (hold == 0);
                end
                default: step = 1'b1;
            endcase
            case (rmode)
                1: data_out_ready = (cyc % 3 == 0);
                2: data_out_ready = 1'($urandom_range(0, 1));
                default: data_out_ready = 1'b1;
            endcase
            if (wr_request) wr_grant = (obs_req + 1 >= gdelay);
            else wr_grant = stray ? 1'($urandom_range(0, 1)) : 1'b0;
            start = stray && (cyc == 6);
            @(negedge clk);
            if (wr_request) begin
                if (obs_first_req < 0) obs_first_req = cyc;
                obs_req++;
            end
            if (mem_ren) begin
                obs_reads++;
                if (!step) obs_ren_nostep++;
            end
            if (step && data_out_valid && data_out_ready) begin
                obs_beats.push_back(data_out);
                obs_beat_cyc.push_back(cyc);
            end
            if (obs_reads - obs_beats.size() > obs_max_out) obs_max_out = obs_reads - obs_beats.size();
            if (wr_complete && step) begin
                obs_complete++; fin = 1; obs_fin_cyc = cyc;
            end
            @(posedge clk); #1;
            if (hold > 0) hold--;
            cyc++;
        end
        start = 1'b0; wr_grant = 1'b0; data_out_ready = 1'b0; step = 1'b1;
        obs_timeout = fin ? 0 : 1;
    endtask

    task automatic test_reset();
        rst = 1'b1; step = 1'b0; start = 1'b0; cfg_wr_index = '0; cfg_wr_length = '0;
        wr_grant = 1'b0; data_out_ready = 1'b0;
        repeat (2) @(posedge clk); #1;
        checks++;
        if ({wr_request, wr_index, wr_length, data_out, data_out_valid, wr_complete, done, busy, i, mem_addr, mem_ren} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got req=%b idx=%h len=%h dout=%h vld=%b cmp=%b done=%b busy=%b i=%h addr=%h ren=%b want all zero",
                     wr_request, wr_index, wr_length, data_out, data_out_valid, wr_complete, done, busy, i, mem_addr, mem_ren);
        end
        rst = 1'b0; step = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL reset_release got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_idle_ignores();
        wr_grant = 1'b1; data_out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || wr_request !== 1'b0 || data_out_valid !== 1'b0 || mem_ren !== 1'b0) begin
                failures++;
                $display("FAIL idle_grant got busy=%b req=%b vld=%b ren=%b want 0", busy, wr_request, data_out_valid, mem_ren);
            end
        end
        @(posedge clk); #1;
        wr_grant = 1'b0; data_out_ready = 1'b0;
    endtask

    task automatic test_basic();
        for (int k = 0; k < 512; k++) mem[k] = 8'(k + 16);
        build_expected(5);
        drive_xfer(5, 32'hA000_0040, 3, 0, 0, 0);
        checks++;
        if (obs_timeout !== 0) begin failures++; $display("FAIL basic_timeout got=%0d want=0", obs_timeout); end
        checks++;
        if (obs_beats.size() !== exp_q.size()) begin
            failures++; $display("FAIL basic_beat_count got=%0d want=%0d", obs_beats.size(), exp_q.size());
        end else foreach (exp_q[k]) begin
            checks++;
            if (obs_beats[k] !== exp_q[k]) begin
                failures++; $display("FAIL basic_beat[%0d] got=%h want=%h", k, obs_beats[k], exp_q[k]);
            end
        end
`ifndef DMA_STORE_PACK_EN
        for (int k = 1; k < obs_beat_cyc.size(); k++) begin
            checks++;
            if (obs_beat_cyc[k] - obs_beat_cyc[k-1] !== 1) begin
                failures++; $display("FAIL basic_consecutive[%0d] got gap=%0d want=1", k, obs_beat_cyc[k] - obs_beat_cyc[k-1]);
            end
        end
`endif
        checks++;
        if (obs_req !== 3) begin failures++; $display("FAIL basic_req_cycles got=%0d want=3", obs_req); end
        checks++;
        if (obs_first_req !== 0) begin failures++; $display("FAIL basic_req_latency got=%0d want=0", obs_first_req); end
        checks++;
        if (obs_complete !== 1) begin failures++; $display("FAIL basic_complete got=%0d want=1", obs_complete); end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL basic_done got done=%b busy=%b want 1 0", done, busy); end
        checks++;
        if (wr_index !== 32'hA000_0040 || wr_length !== 32'd5 || i !== 16'd5) begin
            failures++; $display("FAIL basic_latched got idx=%h len=%h i=%0d want a0000040 5 5", wr_index, wr_length, i);
        end
    endtask

    task automatic test_ready_toggle();
        fill_mem_random();
        build_expected(4);
        drive_xfer(4, 32'h0000_1000, 1, 1, 0, 0);
        checks++;
        if (obs_beats.size() !== exp_q.size()) begin
            failures++; $display("FAIL toggle_beat_count got=%0d want=%0d", obs_beats.size(), exp_q.size());
        end else foreach (exp_q[k]) begin
            checks++;
            if (obs_beats[k] !== exp_q[k]) begin
                failures++; $display("FAIL toggle_beat[%0d] got=%h want=%h", k, obs_beats[k], exp_q[k]);
            end
        end
`ifndef DMA_STORE_PACK_EN
        checks++;
        if (obs_max_out > 2) begin failures++; $display("FAIL toggle_outstanding got=%0d want<=2", obs_max_out); end
`endif
        checks++;
        if (obs_complete !== 1 || done !== 1'b1) begin
            failures++; $display("FAIL toggle_complete got cmp=%0d done=%b want 1 1", obs_complete, done);
        end
    endtask

    task automatic test_zero_len();
        drive_xfer(0, 32'h0000_2000, 1, 0, 0, 0);
        checks++;
        if (obs_req !== 0 || obs_reads !== 0) begin
            failures++; $display("FAIL zero_activity got req=%0d reads=%0d want 0 0", obs_req, obs_reads);
        end
        checks++;
        if (obs_complete !== 1 || obs_fin_cyc !== 0) begin
            failures++; $display("FAIL zero_complete got cnt=%0d cyc=%0d want 1 0", obs_complete, obs_fin_cyc);
        end
        checks++;
        if (done !== 1'b1 || wr_length !== 32'd0 || obs_beats.size() !== 0) begin
            failures++; $display("FAIL zero_done got done=%b len=%0d beats=%0d want 1 0 0", done, wr_length, obs_beats.size());
        end
    endtask

    task automatic test_reset_mid();
        int n, seen;
        fill_mem_random();
        step = 1'b1; data_out_ready = 1'b0; start = 1'b1;
        cfg_wr_index = 32'h0000_3000; cfg_wr_length = 16'd8;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!(busy && i == 16'd2) && n < 60) begin
            wr_grant = wr_request;
            @(posedge clk); #1;
            n++;
        end
        wr_grant = 1'b0;
        checks++;
        if (n >= 60) begin failures++; $display("FAIL rstmid_reach_i2 got i=%0d want 2", i); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({wr_request, wr_index, wr_length, data_out, data_out_valid, wr_complete, done, busy, i, mem_addr, mem_ren} !== '0) begin
            failures++;
            $display("FAIL rstmid_outputs got req=%b idx=%h len=%h dout=%h vld=%b busy=%b i=%0d ren=%b want all zero",
                     wr_request, wr_index, wr_length, data_out, data_out_valid, busy, i, mem_ren);
        end
        seen = 0;
        repeat (2) begin @(negedge clk); if (wr_complete) seen++; end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) begin @(negedge clk); if (wr_complete) seen++; end
        @(posedge clk); #1;
        checks++;
        if (seen !== 0 || busy !== 1'b0) begin
            failures++; $display("FAIL rstmid_no_complete got cmp=%0d busy=%b want 0 0", seen, busy);
        end
        build_expected(7);
        drive_xfer(7, 32'h0000_3100, 2, 0, 0, 0);
        checks++;
        if (obs_beats.size() !== exp_q.size()) begin
            failures++; $display("FAIL rstmid_beat_count got=%0d want=%0d", obs_beats.size(), exp_q.size());
        end else foreach (exp_q[k]) begin
            checks++;
            if (obs_beats[k] !== exp_q[k]) begin
                failures++; $display("FAIL rstmid_beat[%0d] got=%h want=%h", k, obs_beats[k], exp_q[k]);
            end
        end
        checks++;
        if (obs_complete !== 1 || done !== 1'b1) begin
            failures++; $display("FAIL rstmid_restart got cmp=%0d done=%b want 1 1", obs_complete, done);
        end
    endtask

    task automatic test_step_hold();
        fill_mem_random();
        build_expected(6);
        drive_xfer(6, 32'h0000_4000, 1, 0, 2, 0);
        checks++;
        if (obs_beats.size() !== exp_q.size()) begin
            failures++; $display("FAIL stephold_beat_count got=%0d want=%0d", obs_beats.size(), exp_q.size());
        end else foreach (exp_q[k]) begin
            checks++;
            if (obs_beats[k] !== exp_q[k]) begin
                failures++; $display("FAIL stephold_beat[%0d] got=%h want=%h", k, obs_beats[k], exp_q[k]);
            end
        end
        checks++;
        if (obs_ren_nostep !== 0) begin failures++; $display("FAIL stephold_ren got=%0d want=0", obs_ren_nostep); end
        checks++;
        if (obs_complete !== 1 || i !== 16'd6) begin
            failures++; $display("FAIL stephold_complete got cmp=%0d i=%0d want 1 6", obs_complete, i);
        end
    endtask

    task automatic test_busy_ignores();
        fill_mem_random();
        build_expected(10);
        drive_xfer(10, 32'h0BAD_0000, 2, 2, 0, 1);
        checks++;
        if (obs_beats.size() !== exp_q.size()) begin
            failures++; $display("FAIL busyign_beat_count got=%0d want=%0d", obs_beats.size(), exp_q.size());
        end else foreach (exp_q[k]) begin
            checks++;
            if (obs_beats[k] !== exp_q[k]) begin
                failures++; $display("FAIL busyign_beat[%0d] got=%h want=%h", k, obs_beats[k], exp_q[k]);
            end
        end
        checks++;
        if (wr_index !== 32'h0BAD_0000 || wr_length !== 32'd10 || obs_complete !== 1) begin
            failures++; $display("FAIL busyign_latched got idx=%h len=%0d cmp=%0d want 0bad0000 10 1", wr_index, wr_length, obs_complete);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            int len;
            len = $urandom_range(1, 60);
            fill_mem_random();
            build_expected(len);
            drive_xfer(len, $urandom, $urandom_range(1, 5), 2, 1, 1);
            checks++;
            if (obs_beats.size() !== exp_q.size()) begin
                failures++; $display("FAIL rand%0d_beat_count len=%0d got=%0d want=%0d", t, len, obs_beats.size(), exp_q.size());
            end else foreach (exp_q[k]) begin
                checks++;
                if (obs_beats[k] !== exp_q[k]) begin
                    failures++; $display("FAIL rand%0d_beat[%0d] got=%h want=%h", t, k, obs_beats[k], exp_q[k]);
                end
            end
`ifndef DMA_STORE_PACK_EN
            checks++;
            if (obs_max_out > 2) begin failures++; $display("FAIL rand%0d_outstanding got=%0d want<=2", t, obs_max_out); end
`endif
            checks++;
            if (obs_ren_nostep !== 0 || obs_complete !== 1 || done !== 1'b1 || i !== 16'(len)) begin
                failures++;
                $display("FAIL rand%0d_status got ren_nostep=%0d cmp=%0d done=%b i=%0d want 0 1 1 %0d", t, obs_ren_nostep, obs_complete, done, i, len);
            end
        end
    endtask

    task automatic test_wrap();
        fill_mem_random();
        build_expected(515);
        drive_xfer(515, 32'h0000_5000, 1, 0, 0, 0);
        checks++;
        if (obs_beats.size() !== exp_q.size()) begin
            failures++; $display("FAIL wrap_beat_count got=%0d want=%0d", obs_beats.size(), exp_q.size());
        end else foreach (exp_q[k]) begin
            checks++;
            if (obs_beats[k] !== exp_q[k]) begin
                failures++; $display("FAIL wrap_beat[%0d] got=%h want=%h", k, obs_beats[k], exp_q[k]);
            end
        end
        checks++;
        if (i !== 16'd515 || mem_addr !== 9'(515 % 512)) begin
            failures++; $display("FAIL wrap_counters got i=%0d addr=%0d want 515 %0d", i, mem_addr, 515 % 512);
        end
    endtask

`ifdef DMA_STORE_PACK_EN
    task automatic test_pack();
        for (int k = 0; k < 512; k++) mem[k] = 8'(k + 1);
        drive_xfer(6, 32'h0000_6000, 1, 0, 0, 0);
        checks++;
        if (obs_beats.size() !== 2) begin
            failures++; $display("FAIL pack_beat_count got=%0d want=2", obs_beats.size());
        end else begin
            checks++;
            if (obs_beats[0] !== 32'h0403_0201 || obs_beats[1] !== 32'h0000_0605) begin
                failures++; $display("FAIL pack_words got=%h %h want 04030201 00000605", obs_beats[0], obs_beats[1]);
            end
        end
        checks++;
        if (wr_length !== 32'd6 || obs_complete !== 1) begin
            failures++; $display("FAIL pack_length got len=%0d cmp=%0d want 6 1", wr_length, obs_complete);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_idle_ignores();
        test_basic();
        test_ready_toggle();
        test_zero_len();
        test_reset_mid();
        test_step_hold();
        test_busy_ignores();
        test_random();
        test_wrap();
`ifdef DMA_STORE_PACK_EN
        test_pack();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
